// File: rtl/level_num_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// level_num_ctrl_pkg
// Shared definitions for the level/number controller:
//   - FSM state encoding (matches the 2-bit `state` output of the top)
//   - quota(): number of targets a level starts with
// ---------------------------------------------------------------------------
package level_num_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_LVL_UP = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // quota(L) = base + step*L, evaluated at 5 bits. With the default
    // parameters the largest value (level 7) is 26, which fits.
    function automatic logic [4:0] quota(input int base, input int step,
                                         input logic [2:0] lvl);
        int q;
        q = base + step * int'(lvl);
        return 5'(q);
    endfunction

endpackage

// File: rtl/level_num_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes and debounces one raw asynchronous button.
// Ports:
//   clk   - system clock
//   rstn  - synchronous reset, active-low
//   raw   - raw button input (asynchronous, active-high)
//   level - debounced button level
//   pulse - one-cycle pulse on each rising edge of the debounced level
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                // The increment that would bring the count to
                // DEBOUNCE_CYCLES toggles the level instead, so the counter
                // clears in the same cycle the level changes.
                if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= ~level_reg;
                    pulse_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/level_num_ctrl.sv
// ---------------------------------------------------------------------------
// level_num_ctrl
// Game controller feeding the seven-segment level/number display: debounces
// start/hit/miss, counts down remaining targets per level, pauses on level
// up and holds a final done state after the last level.
// Ports:
//   clk       - system clock
//   rstn      - synchronous reset, active-low
//   btn_start - raw start/abort button
//   btn_hit   - raw hit button
//   btn_miss  - raw miss button
//   num       - remaining targets in the current level (registered)
//   level     - current level 0..MAX_LEVEL (registered)
//   state     - FSM state IDLE=0 PLAY=1 LVL_UP=2 DONE=3 (registered)
//   level_up  - one-cycle pulse on entry to LVL_UP (registered)
//   done      - high while in DONE (registered)
// ---------------------------------------------------------------------------
module level_num_ctrl
    import level_num_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PAUSE_CYCLES    = 50_000_000,
    parameter int QUOTA_BASE      = 5,
    parameter int QUOTA_STEP      = 3,
    parameter int MAX_LEVEL       = 7
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       btn_hit,
    input  logic       btn_miss,
    output logic [4:0] num,
    output logic [2:0] level,
    output logic [1:0] state,
    output logic       level_up,
    output logic       done
);

    localparam int         PW    = $clog2(PAUSE_CYCLES + 1);
    localparam logic [4:0] Q0    = quota(QUOTA_BASE, QUOTA_STEP, 3'd0);
    localparam logic [2:0] L_MAX = 3'(MAX_LEVEL);

    // Button index: 0 = start, 1 = hit, 2 = miss
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;

    assign btn_raw = {btn_miss, btn_hit, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rstn (rstn),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .pulse(btn_pulse[gi])
            );
        end
    endgenerate

    // A debounced rising edge always coincides with the button being held,
    // so qualifying with the level keeps the event definition explicit.
    logic start_ev, hit_ev, miss_ev;
    assign start_ev = btn_pulse[0] & btn_level[0];
    assign hit_ev   = btn_pulse[1] & btn_level[1];
    assign miss_ev  = btn_pulse[2] & btn_level[2];

    logic [1:0]    state_reg,    state_next;
    logic [4:0]    num_reg,      num_next;
    logic [2:0]    level_reg,    level_next;
    logic [PW-1:0] pause_reg,    pause_next;
    logic          level_up_reg, level_up_next;
    logic          done_reg,     done_next;

    logic [2:0] level_inc;
    logic [4:0] quota_cur;
    logic [4:0] quota_inc;

    assign level_inc = level_reg + 3'd1;
    assign quota_cur = quota(QUOTA_BASE, QUOTA_STEP, level_reg);
    assign quota_inc = quota(QUOTA_BASE, QUOTA_STEP, level_inc);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            num_reg      <= Q0;
            level_reg    <= 3'd0;
            pause_reg    <= '0;
            level_up_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            num_reg      <= num_next;
            level_reg    <= level_next;
            pause_reg    <= pause_next;
            level_up_reg <= level_up_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and num/level datapath
    always_comb begin
        state_next = state_reg;
        num_next   = num_reg;
        level_next = level_reg;
        pause_next = '0;
        case (state_reg)
            ST_IDLE: begin
                level_next = 3'd0;
                num_next   = Q0;
                if (start_ev) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (start_ev) begin
                    state_next = ST_IDLE;
                    level_next = 3'd0;
                    num_next   = Q0;
                end else if (hit_ev && miss_ev) begin
                    // simultaneous hit and miss cancel out
                end else if (hit_ev && num_reg != 5'd0) begin
                    num_next = num_reg - 5'd1;
                    if (num_reg == 5'd1)
                        state_next = (level_reg == L_MAX) ? ST_DONE : ST_LVL_UP;
                end else if (miss_ev && num_reg < quota_cur) begin
                    num_next = num_reg + 5'd1;
                end
            end
            ST_LVL_UP: begin
                // Pause counter runs 0..PAUSE_CYCLES-1; the last count is
                // the final cycle of the hold.
                if (pause_reg == PW'(PAUSE_CYCLES - 1)) begin
                    state_next = ST_PLAY;
                    level_next = level_inc;
                    num_next   = quota_inc;
                end else begin
                    pause_next = pause_reg + PW'(1);
                end
            end
            default: begin // ST_DONE
                num_next   = 5'd0;
                level_next = L_MAX;
                if (start_ev) begin
                    state_next = ST_IDLE;
                    level_next = 3'd0;
                    num_next   = Q0;
                end
            end
        endcase
    end

    // Registered status outputs derived from the upcoming state
    always_comb begin
        level_up_next = (state_next == ST_LVL_UP) && (state_reg != ST_LVL_UP);
        done_next     = (state_next == ST_DONE);
    end

    assign num      = num_reg;
    assign level    = level_reg;
    assign state    = state_reg;
    assign level_up = level_up_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_level_num_ctrl.sv
module tb_level_num_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_start, btn_hit, btn_miss;
    logic [4:0] num;
    logic [2:0] level;
    logic [1:0] state;
    logic       level_up;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;
    int lu_count = 0;

    level_num_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PAUSE_CYCLES   (8),
        .QUOTA_BASE     (5),
        .QUOTA_STEP     (3),
        .MAX_LEVEL      (7)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_start(btn_start),
        .btn_hit  (btn_hit),
        .btn_miss (btn_miss),
        .num      (num),
        .level    (level),
        .state    (state),
        .level_up (level_up),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (level_up) lu_count++;

    typedef struct {
        bit s;
        bit h;
        bit m;
        int num;
        int lvl;
        int st;
    } vec_t;

    vec_t tbl[17];

    function automatic int quota_m(input int l);
        return 5 + 3 * l;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hold the given buttons for 8 cycles, release for 10, end on a negedge.
    task automatic press(input bit s, input bit h, input bit m);
        btn_start = s; btn_hit = h; btn_miss = m;
        repeat (8) @(posedge clk);
        #1;
        btn_start = 0; btn_hit = 0; btn_miss = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            press(tbl[i].s, tbl[i].h, tbl[i].m);
            $display("vec %0d s=%0d h=%0d m=%0d -> num=%0d level=%0d state=%0d",
                     i, tbl[i].s, tbl[i].h, tbl[i].m, num, level, state);
            check($sformatf("vec%0d_num", i), int'(num), tbl[i].num);
            check($sformatf("vec%0d_level", i), int'(level), tbl[i].lvl);
            check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_num"}, int'(num), 5);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_level_up"}, int'(level_up), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int lu0;
        tbl[0]  = '{1, 0, 0, 5, 0, 0};   // abort from PLAY
        tbl[1]  = '{1, 0, 0, 5, 0, 1};   // start
        tbl[2]  = '{0, 1, 0, 4, 0, 1};
        tbl[3]  = '{0, 1, 0, 3, 0, 1};
        tbl[4]  = '{0, 1, 0, 2, 0, 1};
        tbl[5]  = '{0, 1, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 1, 8, 1, 1};   // miss saturates at quota(1)
        tbl[7]  = '{0, 1, 0, 7, 1, 1};
        tbl[8]  = '{0, 0, 1, 8, 1, 1};
        tbl[9]  = '{0, 1, 1, 8, 1, 1};   // simultaneous cancel
        tbl[10] = '{0, 1, 0, 7, 1, 1};
        tbl[11] = '{0, 1, 0, 6, 1, 1};
        tbl[12] = '{0, 1, 1, 6, 1, 1};
        tbl[13] = '{0, 1, 0, 5, 1, 1};
        tbl[14] = '{0, 1, 0, 4, 1, 1};
        tbl[15] = '{0, 1, 0, 3, 1, 1};
        tbl[16] = '{1, 0, 0, 5, 0, 0};   // abort at level 1, num 3

        // 1. Reset with buttons held high
        rstn = 0; btn_start = 1; btn_hit = 1; btn_miss = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rstn = 1; btn_start = 0; btn_hit = 0; btn_miss = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_reset_state", int'(state), 0);

        // Short start glitch is ignored
        btn_start = 1;
        repeat (3) @(posedge clk);
        #1 btn_start = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("start_glitch_state", int'(state), 0);

        press(1, 0, 0);
        check("start_state", int'(state), 1);
        check("start_num", int'(num), 5);

        // 2. Hit glitch, then held hit with latency check
        btn_hit = 1;
        repeat (3) @(posedge clk);
        #1 btn_hit = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("hit_glitch_num", int'(num), 5);

        btn_hit = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("hit_lat6_num", int'(num), 5);
        @(negedge clk);
        check("hit_lat7_num", int'(num), 4);
        repeat (13) @(posedge clk);
        #1 btn_hit = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("hit_hold_num", int'(num), 4);
        $display("held hit: num=%0d", num);

        // 3. Abort, restart, count down level 0
        run_vecs(0, 5);

        btn_hit = 1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pause%0d_state", i), int'(state), 2);
            check($sformatf("pause%0d_num", i), int'(num), 0);
            check($sformatf("pause%0d_level", i), int'(level), 0);
            check($sformatf("pause%0d_level_up", i), int'(level_up), (i == 0) ? 1 : 0);
            @(negedge clk);
        end
        check("lvl1_state", int'(state), 1);
        check("lvl1_level", int'(level), 1);
        check("lvl1_num", int'(num), 8);
        btn_hit = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("level up: level=%0d num=%0d", level, num);

        // 4/5a. Miss saturation, cancel, abort
        run_vecs(6, 16);

        // 5b. Reset in the middle of LVL_UP
        press(1, 0, 0);
        check("restart_state", int'(state), 1);
        for (int k = 0; k < 4; k++) press(0, 1, 0);
        check("pre_pause_num", int'(num), 1);
        btn_hit = 1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_pause_state", int'(state), 2);
        rstn = 0; btn_hit = 0;
        @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        check_reset("mid_pause_reset");
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("after_reset_level", int'(level), 0);
        check("after_reset_state", int'(state), 0);
        check("after_reset_num", int'(num), 5);
        $display("mid-pause reset: state=%0d level=%0d num=%0d", state, level, num);

        // 6. Full run through all levels
        press(1, 0, 0);
        check("run_start_state", int'(state), 1);
        lu0 = lu_count;
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < quota_m(l); k++) press(0, 1, 0);
            $display("level %0d cleared: state=%0d level=%0d num=%0d done=%0d",
                     l, state, level, num, done);
            if (l < 7) begin
                check($sformatf("run_l%0d_level", l), int'(level), l + 1);
                check($sformatf("run_l%0d_num", l), int'(num), quota_m(l + 1));
                check($sformatf("run_l%0d_state", l), int'(state), 1);
            end else begin
                check("run_done_state", int'(state), 3);
                check("run_done_done", int'(done), 1);
                check("run_done_num", int'(num), 0);
                check("run_done_level", int'(level), 7);
            end
        end
        check("run_level_up_count", lu_count - lu0, 7);

        press(1, 0, 0);
        check("final_state", int'(state), 0);
        check("final_level", int'(level), 0);
        check("final_num", int'(num), 5);
        check("final_done", int'(done), 0);
        $display("restart from done: state=%0d level=%0d num=%0d done=%0d",
                 state, level, num, done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/level_num_ctrl.md
Name: level_num_ctrl

Overview:
- Upstream producer of the `num[4:0]` and `level[2:0]` values consumed by the seven-segment level/number display stage.
- Debounces three raw board buttons: start, hit and miss.
- Runs a per-level countdown of remaining targets and advances the level when the count reaches zero.
- Holds a final done state after the last level.
- Outputs are registered and fed straight to the display stage.

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a debounced button changes level.
- PAUSE_CYCLES, default 50_000_000: length of the level-up hold, in cycles.
- QUOTA_BASE, default 5: target count for level 0.
- QUOTA_STEP, default 3: extra targets added per level. quota(L) = QUOTA_BASE + QUOTA_STEP*L, with a maximum of 26, which fits in 5 bits.
- MAX_LEVEL, default 7: last playable level.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous reset, active-low.
- btn_start  in  1  raw start/abort button, asynchronous, active-high.
- btn_hit  in  1  raw hit button, asynchronous, active-high.
- btn_miss  in  1  raw miss button, asynchronous, active-high.
- num  out  5  remaining targets in the current level.
- level  out  3  current level, 0..MAX_LEVEL.
- state  out  2  FSM state: IDLE=0, PLAY=1, LVL_UP=2, DONE=3.
- level_up  out  1  one-cycle pulse on entry to LVL_UP.
- done  out  1  high while in DONE.

Behaviour:
- This block has exactly one clock, `clk`. Reset is synchronous and active-low on `rstn`; it is sampled only on the rising edge of `clk`.
- Reset values:
  - state = IDLE, level = 0, num = quota(0) = 5, level_up = 0, done = 0.
  - Synchronizer flops, debounced levels and debounce counters are all cleared to 0 (button released).
- Debounce, per button:
  - A 2-flop synchronizer feeds a stability counter.
  - If the synchronized input differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level produces a one-cycle pulse.
  - Latency from a clean raw press to the pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse. Holding a button produces exactly one pulse.
- IDLE:
  - level = 0, num = quota(0).
  - A start pulse moves to PLAY.
  - Hit and miss pulses are ignored.
- PLAY, in priority order:
  - start pulse: go to IDLE; level = 0, num = quota(0). This is an abort.
  - hit and miss in the same cycle: no change.
  - hit: num decrements by 1. If num was 1, num becomes 0, and the next state is DONE when level == MAX_LEVEL, otherwise LVL_UP.
  - miss: num increments by 1, saturating at quota(level).
  - num never underflows; a hit with num == 0 is unreachable in PLAY.
- LVL_UP:
  - level_up = 1 on the first cycle only. num holds 0 and level holds its old value for PAUSE_CYCLES cycles.
  - On the final cycle: level becomes level + 1, num becomes quota(level + 1), and the state returns to PLAY.
  - All button pulses are ignored, including start.
- DONE:
  - num = 0, level = MAX_LEVEL, done = 1.
  - A start pulse moves to IDLE with level = 0 and num = quota(0); done drops in the same cycle.
- Output timing: all outputs are registered. num and level update on the same edge as the state change.
- Reset mid-operation: rstn low on any edge forces the reset values on that edge, including mid-LVL_UP and mid-debounce. The pause counter also clears.
- Width rules:
  - quota is computed at 5 bits.
  - The pause counter is $clog2(PAUSE_CYCLES+1) bits.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits.

Decomposition:
- Shared include file holds:
  - the state encoding localparams (ST_IDLE, ST_PLAY, ST_LVL_UP, ST_DONE);
  - the quota function.
- Sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES:
  - ports: clk, rstn, raw, level, pulse;
  - instantiated three times.
- The FSM and the num/level datapath stay in level_num_ctrl.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, PAUSE_CYCLES=8):
1. Reset: hold rstn=0 for 3 cycles with buttons high -> num=5, level=0, state=0, level_up=0, done=0; no pulse appears after release until a 4-cycle stable press.
2. Debounce: btn_hit high for 3 cycles in PLAY -> num unchanged. btn_hit held for 20 cycles -> exactly one decrement (5→4), first visible 7 cycles after the rising edge.
3. Level advance: start, then 5 hit presses -> num counts 5→0, level_up pulses once, num=0 and level=0 for 8 cycles, then level=1 and num=8 in PLAY.
4. Miss saturation and cancel:
   - At level 1 with num=8, miss -> num stays 8.
   - Hit then miss -> 7 then 8.
   - hit and miss raw edges driven on the same cycle -> num unchanged.
5. Abort and mid-pause reset:
   - Start pressed in PLAY at level 1 with num=3 -> IDLE, level=0, num=5.
   - rstn=0 during LVL_UP -> reset values, no later level change.
6. Full run: complete levels 0..7 (quotas 5,8,...,26); the final hit gives state=3, done=1, num=0, level=7 with no level_up pulse. Start then gives IDLE, level=0, num=5, done=0.
